alu_exec_unit: RTL

//  Parametrised successor to the combinational ALU-control decoder: full 6-bit funct decode plus the execute datapath.

---
 rtl/alu_exec_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: funct decode, single-cycle ADD/SUB/AND/OR/SLT/MFHI/MFLO, iterative MULTU/DIVU into HI/LO.
// Latency: single-cycle ops complete on the accept edge; MULTU/DIVU complete WIDTH edges after accept.
// Backpressure: in_ready is low while a mult/div iterates; in_valid in that window is ignored, not queued.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             illegal
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MULTU = 4'b1000;
  localparam logic [3:0] CTL_DIVU  = 4'b1001;
  localparam logic [3:0] CTL_MFHI  = 4'b1010;
  localparam logic [3:0] CTL_MFLO  = 4'b1011;
  localparam logic [3:0] CTL_ILL   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  state_t state, state_nxt;

  // Iteration registers: acc is the running product high half / partial remainder,
  // shreg is the multiplier being consumed / dividend shifting out while quotient shifts in,
  // opnd is the multiplicand / divisor.
  logic [WIDTH-1:0] acc, shreg, opnd;
  logic [CW-1:0]    cnt;
  logic             dz_pend;

  logic [3:0]       dec_ctl;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] acc_step, sh_step;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic             accept;
  logic             last_iter;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == '0);

  // Decode alu_op/funct into the 4-bit control code; reserved alu_op behaves as add.
  always_comb begin
    dec_ctl = CTL_ADD;
    case (alu_op)
      2'b00:   dec_ctl = CTL_ADD;
      2'b01:   dec_ctl = CTL_SUB;
      2'b10: begin
        case (funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
          6'b011001: dec_ctl = CTL_MULTU;
          6'b011011: dec_ctl = CTL_DIVU;
          6'b010000: dec_ctl = CTL_MFHI;
          6'b010010: dec_ctl = CTL_MFLO;
          default:   dec_ctl = CTL_ILL;
        endcase
      end
      default: dec_ctl = CTL_ADD;
    endcase
  end

  // Single-cycle datapath; illegal codes produce zero.
  always_comb begin
    sc_res = '0;
    case (dec_ctl)
      CTL_ADD:  sc_res = op_a + op_b;
      CTL_SUB:  sc_res = op_a - op_b;
      CTL_AND:  sc_res = op_a & op_b;
      CTL_OR:   sc_res = op_a | op_b;
      CTL_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTL_MFHI: sc_res = hi;
      CTL_MFLO: sc_res = lo;
      default:  sc_res = '0;
    endcase
  end

  // One mult/div iteration: shift-add (right-shifting product) or restoring subtract.
  // A zero divisor naturally yields an all-ones quotient and remainder = dividend.
  always_comb begin
    mul_sum  = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc, shreg[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    acc_step = '0;
    sh_step  = '0;
    if (state == S_MUL) begin
      acc_step = mul_sum[WIDTH:1];
      sh_step  = {mul_sum[0], shreg[WIDTH-1:1]};
    end else begin
      acc_step = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      sh_step  = {shreg[WIDTH-2:0], rem_ge};
    end
  end

  // Next-state: leave IDLE only when a mult/div is accepted; return after the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && dec_ctl == CTL_MULTU)     state_nxt = S_MUL;
        else if (accept && dec_ctl == CTL_DIVU) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath: latch operands on accept, iterate, and register results/pulses on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      shreg     <= '0;
      opnd      <= '0;
      cnt       <= '0;
      dz_pend   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      alu_ctl   <= 4'b0000;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec_ctl == CTL_MULTU) begin
              acc   <= '0;
              shreg <= op_b;
              opnd  <= op_a;
              cnt   <= CW'(WIDTH - 1);
            end else if (dec_ctl == CTL_DIVU) begin
              acc     <= '0;
              shreg   <= op_a;
              opnd    <= op_b;
              dz_pend <= (op_b == '0);
              cnt     <= CW'(WIDTH - 1);
            end else begin
              result    <= sc_res;
              zero      <= (sc_res == '0);
              alu_ctl   <= dec_ctl;
              out_valid <= 1'b1;
              illegal   <= (dec_ctl == CTL_ILL);
            end
          end
        end
        S_MUL, S_DIV: begin
          acc   <= acc_step;
          shreg <= sh_step;
          cnt   <= cnt - 1'b1;
          if (last_iter) begin
            hi        <= acc_step;
            lo        <= sh_step;
            result    <= sh_step;
            zero      <= (sh_step == '0);
            alu_ctl   <= (state == S_MUL) ? CTL_MULTU : CTL_DIVU;
            out_valid <= 1'b1;
            div_zero  <= (state == S_DIV) && dz_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
